tc_timer: RTL

//  Programmable down-counting timer; one instance per TC0/TC1. Sits on the data side of the pipelined CPU,

---
 rtl/tc_pkg.sv | 26 ++
 rtl/tc_timer_if.sv | 13 +
 rtl/tc_timer.sv | 97 +++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Shared constants and types for the TC0/TC1 programmable timers.
package tc_pkg;

  // Register word offsets seen by the bridge
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  // MODE encodings; 2 and 3 behave as one-shot
  localparam logic [1:0] TC_ONESHOT = 2'd0;
  localparam logic [1:0] TC_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/tc_timer_if.sv
// Bridge-side register bus for one timer instance plus its interrupt line.
interface tc_timer_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  // Bridge / CPU side
  modport master (output we, addr, wdata, input rdata, irq);
  // Timer side
  modport slave  (input we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/tc_timer.sv
// Programmable down-counting timer (TC0/TC1) with one-shot and auto-reload modes.
module tc_timer
  import tc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  tc_timer_if.slave  bus
);

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag;
  tc_state_e        state;
  logic [31:0]      rdata_mux;
  logic             unused_wdata;

  // Register file and FSM; the software write is applied after the FSM so it wins on EN/irq_flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      mode     <= TC_ONESHOT;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= LOAD;
        end
        LOAD: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            count <= preset;
            state <= CNT;
          end
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          state <= IDLE;
          if (mode == TC_RELOAD) irq_flag <= 1'b0;
          else                   en       <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (bus.we) begin
        case (bus.addr)
          TC_CTRL: begin
            en       <= bus.wdata[CTRL_EN];
            mode     <= bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            im       <= bus.wdata[CTRL_IM];
            irq_flag <= 1'b0;
          end
          TC_PRESET: begin
            preset   <= bus.wdata[CNT_W-1:0];
            irq_flag <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Combinational register read, zero-extended to the bus width
  always_comb begin
    rdata_mux = '0;
    case (bus.addr)
      TC_CTRL:   rdata_mux = {28'd0, im, mode, en};
      TC_PRESET: rdata_mux = 32'(preset);
      TC_COUNT:  rdata_mux = 32'(count);
      default:   rdata_mux = '0;
    endcase
  end

  assign bus.rdata    = rdata_mux;
  assign bus.irq      = im & irq_flag;
  assign unused_wdata = ^bus.wdata;

endmodule
